// File: rtl/drv_teclado_pkg.sv
// drv_teclado_pkg: shared states, key-code table and helpers for the keypad driver
package drv_teclado_pkg;
  typedef enum logic [1:0] {IDLE_SCAN, DEBOUNCE, ACCEPT, WAIT_RELEASE} state_t;
  localparam logic [4:0] KEY_A    = 5'd10;
  localparam logic [4:0] KEY_B    = 5'd11;
  localparam logic [4:0] KEY_C    = 5'd12;
  localparam logic [4:0] KEY_D    = 5'd13;
  localparam logic [4:0] KEY_STAR = 5'd14;
  localparam logic [4:0] KEY_HASH = 5'd15;
  localparam logic [4:0] KEY_NONE = 5'd31;
  localparam logic [4:0] KEY_MAP [4][4] = '{
    '{5'd1, 5'd2, 5'd3, KEY_A},
    '{5'd4, 5'd5, 5'd6, KEY_B},
    '{5'd7, 5'd8, 5'd9, KEY_C},
    '{KEY_STAR, 5'd0, KEY_HASH, KEY_D}
  };
  function automatic logic [1:0] low_row(input logic [3:0] f);
    return !f[0] ? 2'd0 : !f[1] ? 2'd1 : !f[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, tick-sampled debounce and rising-edge pulse for a pushbutton
module btn_debounce #(
  parameter int DEB_SAMPLES = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic tick,
  output logic pulse
);
  localparam int CW = $clog2(DEB_SAMPLES + 1);
  logic [1:0] sync_q, sync_d;
  logic state_q, state_d, pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d  = {sync_q[0], btn};
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (tick) begin
      if (sync_q[1] == state_q) cnt_d = '0;
      else if (int'(cnt_q) + 1 >= DEB_SAMPLES) begin
        state_d = sync_q[1];
        cnt_d   = '0;
        pulse_d = sync_q[1];
      end else cnt_d = cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  assign pulse = pulse_q;
endmodule

// File: rtl/drv_teclado.sv
// drv_teclado: 4x4 keypad scanner with debounce, 3-digit position tracking and debounced enter
module drv_teclado
  import drv_teclado_pkg::*;
#(
  parameter int SCAN_TICKS  = 50000,
  parameter int DEB_SAMPLES = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic [3:0] fila,
  output logic [3:0] col,
  output logic [4:0] digito,
  output logic [1:0] desp,
  output logic       enter_sync
);
  localparam int TW = $clog2(SCAN_TICKS + 1);
  localparam int DW = $clog2(DEB_SAMPLES + 1);
  state_t state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [3:0] f1_q, f1_d, f2_q, f2_d;
  logic [1:0] c_q, c_d, row_q, row_d, desp_q, desp_d;
  logic [4:0] digito_q, digito_d, key;
  logic adv_q, adv_d, tick, dn, enter_p;
  btn_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_enter (
    .clk(clk), .rst_n(reset), .btn(enter), .tick(tick), .pulse(enter_p)
  );
  assign tick = int'(tcnt_q) == SCAN_TICKS - 1;
  assign dn   = int'(dcnt_q) + 1 >= DEB_SAMPLES;
  assign key  = state_q == ACCEPT ? KEY_MAP[row_q][c_q] : KEY_NONE;
  always_comb begin
    tcnt_d   = tick ? '0 : tcnt_q + TW'(1);
    f1_d     = fila;
    f2_d     = f1_q;
    state_d  = state_q;
    dcnt_d   = dcnt_q;
    c_d      = c_q;
    row_d    = row_q;
    digito_d = {1'b0, digito_q[3:0]};
    desp_d   = desp_q;
    adv_d    = 1'b0;
    case (state_q)
      IDLE_SCAN:
        if (tick) begin
          if (f2_q != 4'hF) begin
            row_d   = low_row(f2_q);
            dcnt_d  = DW'(1);
            state_d = DEB_SAMPLES <= 1 ? ACCEPT : DEBOUNCE;
          end else c_d = c_q + 2'd1;
        end
      DEBOUNCE:
        if (tick) begin
          if (f2_q != 4'hF && low_row(f2_q) == row_q) begin
            state_d = dn ? ACCEPT : DEBOUNCE;
            dcnt_d  = dn ? '0 : dcnt_q + DW'(1);
          end else begin
            state_d = IDLE_SCAN;
            dcnt_d  = '0;
          end
        end
      ACCEPT: begin
        state_d = WAIT_RELEASE;
        dcnt_d  = '0;
        if (key < 5'd10) begin
          digito_d = {1'b1, key[3:0]};
          adv_d    = !enter_p;
        end
        if (key == KEY_STAR) desp_d = 2'd0;
      end
      WAIT_RELEASE:
        if (tick) begin
          if (f2_q == 4'hF) begin
            state_d = dn ? IDLE_SCAN : WAIT_RELEASE;
            dcnt_d  = dn ? '0 : dcnt_q + DW'(1);
          end else dcnt_d = '0;
        end
    endcase
    // enter overrides any pending advance so a coincident press leaves desp at 0
    if (adv_q) desp_d = desp_q == 2'd2 ? 2'd0 : desp_q + 2'd1;
    if (enter_p) desp_d = 2'd0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= IDLE_SCAN;
      tcnt_q   <= '0;
      dcnt_q   <= '0;
      f1_q     <= 4'hF;
      f2_q     <= 4'hF;
      c_q      <= 2'd0;
      row_q    <= 2'd0;
      digito_q <= '0;
      desp_q   <= 2'd0;
      adv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      dcnt_q   <= dcnt_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      c_q      <= c_d;
      row_q    <= row_d;
      digito_q <= digito_d;
      desp_q   <= desp_d;
      adv_q    <= adv_d;
    end
  assign col        = ~(4'b0001 << c_q);
  assign digito     = digito_q;
  assign desp       = desp_q;
  assign enter_sync = enter_p;
endmodule

// File: tb/tb_drv_teclado.sv
// tb_drv_teclado: directed self-checking bench for drv_teclado with SCAN_TICKS=4, DEB_SAMPLES=3
module tb_drv_teclado;
  logic clk = 1'b0, reset = 1'b0, enter = 1'b0, key_on = 1'b0;
  logic [1:0] kr = 2'd0, kc = 2'd0, desp;
  logic [3:0] fila, col;
  logic [4:0] digito;
  logic enter_sync;
  int n_chk = 0, n_fail = 0, n_str = 0, n_ent = 0, base;
  logic [4:0] sd [64];
  logic [1:0] sp [64];
  logic [4:0] exp_d [4] = '{5'h17, 5'h18, 5'h19, 5'h11};
  logic [1:0] exp_p [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
  drv_teclado #(.SCAN_TICKS(4), .DEB_SAMPLES(3)) dut (
    .clk(clk), .reset(reset), .enter(enter), .fila(fila),
    .col(col), .digito(digito), .desp(desp), .enter_sync(enter_sync)
  );
  always #5 clk = ~clk;
  assign fila = (key_on && col[kc] == 1'b0) ? ~(4'b0001 << kr) : 4'hF;
  always @(negedge clk) begin
    if (digito[4] === 1'b1) begin
      if (n_str < 64) begin
        sd[n_str] = digito;
        sp[n_str] = desp;
      end
      n_str = n_str + 1;
    end
    if (enter_sync === 1'b1) n_ent = n_ent + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b0; key_on = 1'b0; enter = 1'b0;
    step(3);
    reset = 1'b1;
  endtask
  task automatic press(input logic [1:0] r, input logic [1:0] c);
    kr = r; kc = c; key_on = 1'b1;
    step(40);
    key_on = 1'b0;
    step(40);
  endtask
  initial begin
    step(2);
    check("rst_col", col, 4'b1110);
    check("rst_digito", digito, 0);
    check("rst_desp", desp, 0);
    check("rst_enter", enter_sync, 0);
    do_reset;
    step(3);  check("col0", col, 4'b1110);
    step(1);  check("col1", col, 4'b1101);
    step(4);  check("col2", col, 4'b1011);
    step(4);  check("col3", col, 4'b0111);
    step(4);  check("col_wrap", col, 4'b1110);
    check("idle_digito", digito, 0);
    check("idle_desp", desp, 0);
    do_reset;
    base = n_str;
    press(2'd1, 2'd1);
    check("k5_count", n_str - base, 1);
    check("k5_digito", sd[base], 5'h15);
    check("k5_desp", sp[base], 0);
    check("k5_desp_after", desp, 1);
    do_reset;
    base = n_str;
    press(2'd2, 2'd0); press(2'd2, 2'd1); press(2'd2, 2'd2); press(2'd0, 2'd0);
    check("seq_count", n_str - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("seq_digito%0d", i), sd[base + i], exp_d[i]);
      check($sformatf("seq_desp%0d", i), sp[base + i], exp_p[i]);
    end
    do_reset;
    base = n_str;
    kr = 2'd1; kc = 2'd1;
    for (int i = 0; i < 10; i++) begin
      key_on = ~key_on;
      step(2);
    end
    key_on = 1'b1; step(40);
    key_on = 1'b0; step(40);
    check("bounce_count", n_str - base, 1);
    check("bounce_digito", sd[base], 5'h15);
    do_reset;
    base = n_str;
    press(2'd3, 2'd2);
    check("hash_count", n_str - base, 0);
    check("hash_desp", desp, 0);
    press(2'd0, 2'd0); press(2'd0, 2'd1);
    check("pre_star_desp", desp, 2);
    press(2'd3, 2'd0);
    check("star_count", n_str - base, 2);
    check("star_desp", desp, 0);
    do_reset;
    base = n_ent;
    kr = 2'd0; kc = 2'd0; key_on = 1'b1;
    step(40);
    check("ent_pre_desp", desp, 1);
    enter = 1'b1; step(30);
    enter = 1'b0; step(30);
    check("ent_count", n_ent - base, 1);
    check("ent_desp", desp, 0);
    key_on = 1'b0; step(40);
    check("ent_desp_rel", desp, 0);
    do_reset;
    base = n_str;
    kr = 2'd1; kc = 2'd1; key_on = 1'b1;
    step(10);
    reset = 1'b0;
    #1;
    check("mid_col", col, 4'b1110);
    check("mid_digito", digito, 0);
    check("mid_desp", desp, 0);
    check("mid_enter", enter_sync, 0);
    key_on = 1'b0;
    step(3);
    reset = 1'b1;
    step(60);
    check("mid_no_strobe", n_str - base, 0);
    press(2'd1, 2'd1);
    check("mid_new_press", n_str - base, 1);
    check("mid_new_digito", sd[base], 5'h15);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/drv_teclado.md
DRV_TECLADO -- requirements
Module: drv_teclado

Interface
REQ-001 Parameter SCAN_TICKS, default 50000: clocks per column step (1 ms at 50 MHz).
REQ-002 Parameter DEB_SAMPLES, default 20: consecutive stable scan ticks needed to accept a press, release or enter edge.
REQ-003 Port clk, input, 1: single system clock; all logic rising-edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port enter, input, 1: raw asynchronous enter pushbutton, active-high.
REQ-006 Port fila, input, 4: keypad rows, active-low (pull-ups); fila[0] is the top row.
REQ-007 Port col, output, 4: keypad column drive, active-low one-hot; col[0] is the left column.
REQ-008 Port digito, output, 5: digito[3:0] holds the last accepted digit 0-9; digito[4] is a one-clock new-digit strobe.
REQ-009 Port desp, output, 2: write position of the current digit, 0=units, 1=tens, 2=hundreds.
REQ-010 Port enter_sync, output, 1: one-clock pulse per debounced enter press.

Function
REQ-011 fila and enter SHALL each pass through a 2-flop synchronizer before use.
REQ-012 A tick counter SHALL produce a 1-clock scan tick every SCAN_TICKS clocks.
REQ-013 While idle, col SHALL rotate on every tick: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
REQ-014 Key map as row/col (r,c) SHALL be:
- r0: 1 2 3 A
- r1: 4 5 6 B
- r2: 7 8 9 C
- r3: * 0 # D
REQ-015 If any synced fila bit is low on a tick, rotation SHALL freeze and the lowest-index low row SHALL be the candidate key.
REQ-016 The candidate SHALL be accepted after DEB_SAMPLES consecutive ticks with the same row low; any mismatch returns the block to idle scanning.
REQ-017 On acceptance of a digit key, digito[3:0] SHALL load the value and digito[4] SHALL pulse for exactly one clock.
REQ-018 desp SHALL advance on the clock after the strobe, sequence 0 -> 1 -> 2 -> 0.
REQ-019 The strobe SHALL carry the desp value in effect before that advance.
REQ-020 Key '*' SHALL force desp to 0 with no strobe.
REQ-021 Keys A, B, C, D and # SHALL be ignored: no strobe, desp unchanged.
REQ-022 After acceptance the block SHALL wait until all rows are high for DEB_SAMPLES consecutive ticks before resuming rotation.
REQ-023 A held key SHALL generate exactly one acceptance, with no auto-repeat.
REQ-024 State machine: IDLE_SCAN -> DEBOUNCE -> ACCEPT (1 clk) -> WAIT_RELEASE -> IDLE_SCAN.
REQ-025 Enter SHALL be debounced to DEB_SAMPLES stable ticks, independently of the keypad machine.
REQ-026 A debounced enter rising edge SHALL pulse enter_sync for 1 clock and force desp to 0.
REQ-027 If enter and a digit acceptance occur in the same clock, the strobe SHALL still be emitted and enter SHALL win, leaving desp=0.

Reset
REQ-028 reset low SHALL asynchronously force: col=1110, digito=0, desp=0, enter_sync=0, all counters 0, state IDLE_SCAN.
REQ-029 Reset asserted mid-debounce or mid-release SHALL discard the pending key with no strobe after release of reset.

Structure
REQ-030 A shared package SHALL hold the state enum, the 4x4 key-code table, and codes KEY_STAR and KEY_NONE.
REQ-031 One sub-module, btn_debounce, SHALL implement the synchronizer, debounce and rising-edge pulse for enter.
REQ-032 btn_debounce SHALL be reusable for other pushbuttons.
REQ-033 Target size: 150-300 lines of RTL.

Verification (SCAN_TICKS=4, DEB_SAMPLES=3)
REQ-034 Reset, no keys -> col cycles 1110, 1101, 1011, 0111 every 4 clocks; digito=0, desp=0.
REQ-035 Hold '5' (r1,c1) for 40 clocks -> exactly one strobe with digito=5'h15 and desp=0; then desp=1.
REQ-036 Press 7, 8, 9, 1 with releases -> strobes carry desp 0, 1, 2, 0; digito[3:0]=7, 8, 9, 1.
REQ-037 '5' bouncing (fila[1] toggling every 2 clocks) for 20 clocks, then stable -> one strobe only after stability.
REQ-038 Press '#', then '*' after desp=2 -> no strobes; desp goes to 0 on '*'.
REQ-039 Enter press during WAIT_RELEASE with desp=1 -> one enter_sync pulse; desp=0.
REQ-040 Reset pulsed low mid-DEBOUNCE -> outputs return to reset values immediately; no strobe until a new full press.
